// File: rtl/ac3_pkg.sv
// ac3_pkg: definitions shared by the AC3 accumulation-stage blocks.
//   ac3_state_t - FSM state encoding for frame-based accumulators.
//   ac3_width() - accumulator width: enough bits for M-lane dot products of
//                 Pa x Pw operands, summed over up to MNO contributions.
package ac3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } ac3_state_t;

    localparam int AC3_NUM_REGS = 4;

    function automatic int ac3_width(input int m, input int pa, input int pw, input int mno);
        return $clog2(m) + pa + pw + $clog2(mno);
    endfunction

endpackage

// File: rtl/ac3_mux.sv
// ac3_mux: 4:1 selector of W-bit words.
//   d0..d3   : candidate words
//   sel_w_en : 2-bit select
//   y        : selected word
module ac3_mux #(
    parameter int W = 25
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel_w_en,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel_w_en)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/ac3_acc.sv
// ac3_acc: frame accumulator. Partial sums arriving from AC2 are added into
// one of four registers (chosen by in_sel) until a beat flagged in_last, then
// the four registers are streamed out in index order 0..3 and done pulses.
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a new frame (honoured in IDLE only)
//   in_data/sel/last     : beat payload, qualified by in_valid / in_ready
//   out_data/idx         : drained register value and its index
//   out_valid/out_ready  : drain handshake
//   done                 : one-cycle pulse after the index-3 drain beat
module ac3_acc
    import ac3_pkg::*;
#(
    parameter  int M   = 16,
    parameter  int Pa  = 8,
    parameter  int Pw  = 4,
    parameter  int MNO = 288,
    localparam int W   = ac3_width(M, Pa, Pw, MNO)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         done
);

    ac3_state_t state_q, state_d;
    logic [AC3_NUM_REGS-1:0][W-1:0] acc_q;
    logic [1:0]   idx_q;
    logic         done_q;
    logic [W-1:0] mux_y;
    logic         beat_acc;
    logic         drain_hs;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DRAIN);
    assign beat_acc  = in_valid & in_ready;
    assign drain_hs  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ACC;
            ST_ACC:   if (beat_acc && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_hs && idx_q == 2'd3) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sums wrap modulo 2^W; W is sized so a legal frame never overflows.
    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else if (state_q == ST_IDLE && start)
            acc_q <= '0;
        else if (beat_acc)
            acc_q[in_sel] <= acc_q[in_sel] + in_data;
    end

    // idx naturally wraps 3 -> 0 on the final handshake, ready for next frame.
    always_ff @(posedge clk) begin
        if (rst)
            idx_q <= 2'd0;
        else if (beat_acc && in_last)
            idx_q <= 2'd0;
        else if (drain_hs)
            idx_q <= idx_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= drain_hs && (idx_q == 2'd3);
    end

    ac3_mux #(.W(W)) u_mux (
        .d0       (acc_q[0]),
        .d1       (acc_q[1]),
        .d2       (acc_q[2]),
        .d3       (acc_q[3]),
        .sel_w_en (idx_q),
        .y        (mux_y)
    );

    // Outputs read as zero outside DRAIN so reset and idle look clean.
    assign out_data = out_valid ? mux_y : '0;
    assign out_idx  = out_valid ? idx_q : 2'd0;
    assign done     = done_q;

endmodule

// File: tb/tb_ac3_acc.sv
// tb_ac3_acc: scoreboard bench for ac3_acc. The driver keeps four plain
// integer sums per frame; on the last beat it queues the four expected drain
// words, and a negedge monitor pops and compares on every drain handshake.
module tb_ac3_acc;
    localparam int W = 25;

    logic         clk = 1'b0;
    logic         rst, start, in_last, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_ready, out_valid, done;
    logic [W-1:0] out_data;
    logic [1:0]   out_idx;

    always #5 clk = ~clk;

    ac3_acc dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    typedef struct {
        logic [1:0]   idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t         q[$];
    exp_t         e_mon;
    int           exp_done = 0;
    logic [W-1:0] mdl[4];
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every drain handshake must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: idx=%0d data=%0d, expected no output", out_idx, out_data);
            end else begin
                e_mon = q.pop_front();
                chk("out_idx", out_idx, e_mon.idx);
                chk("out_data", out_data, e_mon.data);
            end
        end
        if (!rst && done) begin
            chk("done_expected", exp_done > 0, 1);
            chk("done_after_all_drained", q.size(), 0);
            if (exp_done > 0) exp_done--;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
    endtask

    task automatic beat(input logic [1:0] sel, input logic [W-1:0] data, input bit last, input int gap);
        chk("in_ready_in_acc", in_ready, 1);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        mdl[sel] = mdl[sel] + data;
        if (last) begin
            for (int i = 0; i < 4; i++) q.push_back('{idx: 2'(i), data: mdl[i]});
            exp_done++;
        end
        repeat (gap) cyc();
    endtask

    task automatic run_drain(input bit rnd);
        bit seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            out_ready = rnd ? 1'($urandom) : 1'b1;
            cyc();
            if (done) seen = 1;
        end
        out_ready = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got no done in 200 cycles, expected done");
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_sel = 2'd0; out_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        chk_idle_outputs("reset");

        // Basic frame: expect (0,8),(1,7),(2,0),(3,1) then done.
        do_start();
        beat(2'd0, 25'd5, 0, 0);
        beat(2'd1, 25'd7, 0, 0);
        beat(2'd0, 25'd3, 0, 0);
        beat(2'd3, 25'd1, 1, 0);
        run_drain(0);

        // Start in the done cycle; start during ACC ignored; idx 2 wraps to 1.
        do_start();
        chk("b2b_in_ready", in_ready, 1);
        beat(2'd1, 25'd4, 0, 1);
        start = 1'b1;
        beat(2'd1, 25'd6, 0, 0);
        start = 1'b0;
        beat(2'd2, {W{1'b1}}, 0, 0);
        beat(2'd2, 25'd2, 1, 0);
        run_drain(1);

        // Reset after two accepted beats abandons the frame.
        repeat (2) cyc();
        do_start();
        beat(2'd0, 25'd9, 0, 0);
        beat(2'd3, 25'd11, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle_outputs("mid_acc_reset");
        cyc();
        chk("no_done_after_reset", done, 0);
        do_start();
        beat(2'd1, 25'd5, 1, 0);
        run_drain(1);

        // Stall at idx 1 for three cycles.
        repeat (2) cyc();
        do_start();
        beat(2'd0, 25'd10, 0, 0);
        beat(2'd1, 25'd20, 1, 0);
        chk("drain_out_valid", out_valid, 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_idx", out_idx, 1);
            chk("stall_out_data", out_data, 20);
            chk("stall_done", done, 0);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        run_drain(0);

        // 288 beats of 2^16-1 into sel 0 with in_valid toggling.
        repeat (2) cyc();
        do_start();
        for (int i = 0; i < 288; i++) beat(2'd0, 25'h0_FFFF, i == 287, 1);
        run_drain(1);

        // Randomized frames, some with stray start pulses during ACC.
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 2)) cyc();
            do_start();
            begin
                int nb = $urandom_range(1, 12);
                for (int b = 0; b < nb; b++) begin
                    start = 1'($urandom_range(0, 3) == 0);
                    beat(2'($urandom), W'($urandom), b == nb - 1, $urandom_range(0, 2));
                    start = 1'b0;
                end
            end
            run_drain(1);
        end

        repeat (3) cyc();
        chk("queue_empty", q.size(), 0);
        chk("pending_done", exp_done, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ac3_acc.md
AC3_ACC -- requirements
Module: ac3_acc

Interface
REQ-001 SHALL have parameter M, default 16, meaning register dimension.
REQ-002 SHALL have parameter Pa, default 8, meaning activation precision.
REQ-003 SHALL have parameter Pw, default 4, meaning weight precision.
REQ-004 SHALL have parameter MNO, default 288, meaning max contributions per output.
REQ-005 SHALL use derived width W = $clog2(M)+Pa+Pw+$clog2(MNO), which is 25 at defaults.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: begin a new frame.
REQ-009 SHALL have port in_data, input, W bits: unsigned partial sum from AC2.
REQ-010 SHALL have port in_sel, input, 2 bits: target output register index 0..3.
REQ-011 SHALL have port in_last, input, 1 bit: final beat of frame.
REQ-012 SHALL have port in_valid, input, 1 bit: in_data, in_sel and in_last are valid.
REQ-013 SHALL have port in_ready, output, 1 bit: block accepts input.
REQ-014 SHALL have port out_data, output, W bits: drained accumulator value.
REQ-015 SHALL have port out_idx, output, 2 bits: register index of out_data.
REQ-016 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-017 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse after the last drain beat.

Function
REQ-019 SHALL implement FSM states IDLE, ACC and DRAIN.
REQ-020 SHALL in IDLE, on start=1, clear acc[0..3] to 0 and enter ACC next cycle; other inputs ignored.
REQ-021 SHALL drive in_ready=1 only in ACC; out_valid=1 only in DRAIN.
REQ-022 SHALL treat a beat as accepted when in_valid & in_ready; at the next edge acc[in_sel] <= acc[in_sel] + in_data, modulo 2^W (1-cycle latency, no saturation).
REQ-023 SHALL leave registers not selected by an accepted beat unchanged; cycles with in_valid=0 change nothing.
REQ-024 SHALL, when an accepted beat has in_last=1, still add that beat, then enter DRAIN with drain index 0.
REQ-025 SHALL in DRAIN drive out_data=acc[idx] and out_idx=idx, selected through a 4:1 mux on idx.
REQ-026 SHALL advance idx on out_valid & out_ready; out_data and out_idx are held stable while out_ready=0.
REQ-027 SHALL, on the handshake at idx=3, pulse done for exactly one cycle, enter IDLE and leave acc values intact.
REQ-028 SHALL ignore start while in ACC or DRAIN.
REQ-029 SHALL allow back-to-back frames: start asserted in the cycle done=1 (state IDLE) is honoured.
REQ-030 SHALL accept in_last on the first beat of a frame (single-beat frame).

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set state=IDLE, acc[0..3]=0, idx=0, in_ready=0, out_valid=0, out_data=0, out_idx=0 and done=0.
REQ-032 SHALL give rst priority over all other inputs; reset mid-ACC or mid-DRAIN abandons the frame with no done pulse.

Structure
REQ-033 SHALL take the FSM state enum and the width function from shared package ac3_pkg, reused by neighbouring AC3 blocks.
REQ-034 SHALL use the existing 4:1 ac3_mux as the single sub-module for drain selection, with sel_w_en driven by idx.

Verification
REQ-035 SHALL cover: rst; start; beats (sel,data) (0,5),(1,7),(0,3),(3,1 last) with out_ready=1 -> outputs (0,8),(1,7),(2,0),(3,1), then done=1 for one cycle.
REQ-036 SHALL cover: acc[2]=2^25-1, beat (2,2,last) -> drained value for idx 2 = 1 (wrap-around).
REQ-037 SHALL cover: in DRAIN, out_ready=0 for 3 cycles at idx=1 -> out_data/out_idx stable, no done, in_ready=0.
REQ-038 SHALL cover: rst asserted after 2 accepted beats -> next cycle all outputs 0, state IDLE, no done; new frame drains fresh sums.
REQ-039 SHALL cover: start pulsed during ACC -> ignored, accumulations preserved; start in the done cycle -> ACC next cycle with cleared accs.
REQ-040 SHALL cover: in_valid toggling with in_ready=1, 288 beats to sel 0 of data 2^16-1 -> drained value for idx 0 = 288*(2^16-1).
